touch_sample_filter: RTL
========================

Name: touch_sample_filter

Overview:
- Sits between the LT24 touchscreen ADC driver and the painter.
- Averages bursts of raw 12-bit X/Y ADC samples while the pen is down, discards settling samples and noisy bursts, and emits one clean coordinate per burst.
- Each coordinate goes out as a single-cycle pos_ready pulse, issued only when the painter reports painter_ready.
- This stops the painter from seeing jittery or repeated positions and from missing positions while it is busy.

Parameters:
- SAMPLE_LOG2, 2, log2 of samples averaged per burst (burst = 4).
- DISCARD_SAMPLES, 2, samples dropped after each pen-down edge (settling); 0 allowed.
- MAX_SPREAD, 64, max allowed (max-min) per axis within a burst; larger spread rejects the burst.
- ACC_WIDTH, 12+SAMPLE_LOG2, accumulator width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- en  in  1  global enable; low freezes all state
- pen_down  in  1  pen-contact flag from the touchscreen driver, already synchronised
- sample_valid  in  1  one-cycle strobe: sample_x/sample_y valid
- sample_x  in  12  raw X ADC value
- sample_y  in  12  raw Y ADC value
- painter_ready  in  1  painter is idle and can accept a position
- pos_ready  out  1  one-cycle strobe: x_pos/y_pos hold a new filtered position
- x_pos  out  12  filtered X
- y_pos  out  12  filtered Y
- pen_active  out  1  high in any state other than IDLE
- reject_cnt  out  8  saturating count of rejected bursts

Behaviour:
- Reset values: state IDLE; pos_ready 0; x_pos, y_pos 0; pen_active 0; reject_cnt 0; accumulators, min/max and counters cleared.
- en=0: no state, counter, accumulator or output register changes; sample_valid is ignored (sample lost); pos_ready forced 0.
- States:
  - IDLE: wait for pen_down=1, then go to SETTLE (or ACCUM if DISCARD_SAMPLES=0). Clear the discard counter, the sample counter and the accumulators.
  - SETTLE: count accepted samples and drop them. After the DISCARD_SAMPLES-th sample, go to ACCUM.
  - ACCUM: on each sample_valid, add sample_x/sample_y to sum_x/sum_y and update min/max per axis. The first sample of a burst loads min and max directly. After the 2^SAMPLE_LOG2-th sample, go to CHECK on the same edge.
  - CHECK: one cycle.
    - If (max_x-min_x) <= MAX_SPREAD and (max_y-min_y) <= MAX_SPREAD: register x_pos = sum_x >> SAMPLE_LOG2 and y_pos = sum_y >> SAMPLE_LOG2 (truncating), then go to EMIT.
    - Otherwise increment reject_cnt (saturates at 255) and go to ACCUM.
    - Either way, clear the sums, min/max and sample counter.
  - EMIT: pos_ready = (state==EMIT) && painter_ready && pen_down && en, combinational. The FSM leaves for ACCUM on the edge where pos_ready=1. With painter_ready=0 it waits indefinitely and x_pos/y_pos stay stable.
- sample_valid in CHECK or EMIT is dropped; the next burst starts fresh in ACCUM.
- pen_down=0 in any non-IDLE state (and en=1): go to IDLE next edge.
  - The partial burst is discarded and not counted as a reject.
  - A pending EMIT is abandoned with no pulse; pen-up wins over a simultaneous painter_ready.
- x_pos/y_pos keep their last emitted value across pen-up and are only overwritten in CHECK.
- Latency: with painter_ready=1 and en=1, the last burst sample accepted at edge t gives CHECK during cycle t..t+1 and pos_ready high during cycle t+1..t+2 (one cycle).
- pos_ready is never high for two consecutive cycles. At most one pulse per burst.
- Spread compare is unsigned 12-bit; max >= min by construction.
- reset mid-burst or mid-EMIT: returns to reset values on the next edge.

Decomposition:
- Shared package: FSM state encodings (3-bit: IDLE, SETTLE, ACCUM, CHECK, EMIT) and the ADC width constant 12.
- One natural sub-module, axis_accumulator, instantiated twice (X, Y):
  - inputs: clk, reset, clear, load_first, add, sample.
  - outputs: sum, min, max.
- The FSM, counters and reject_cnt live in the top.

Test Plan:
1. Pen down; 2 samples discarded; then 4 samples X=1000,1004,1008,1012 and Y=500 each; painter_ready=1 -> one pos_ready pulse, x_pos=1006, y_pos=500, 2 cycles after the 4th sample. reject_cnt=0.
2. Burst X=100,100,100,300 (spread 200) -> no pulse, reject_cnt=1. Next burst of X=200 ×4 -> x_pos=200.
3. Valid burst with painter_ready=0 for 50 cycles, then 1 -> pos_ready exactly one cycle after painter_ready rises. x_pos stable throughout. Samples during the wait are dropped.
4. pen_down falls after 3 ACCUM samples, and separately during EMIT -> no pulse, state IDLE, pen_active=0. Re-press requires 2 discards again.
5. en=0 during ACCUM with 2 samples presented -> samples ignored. After en=1, 4 further samples are needed for a pulse. pos_ready stays 0 while en=0.
6. 300 consecutive rejected bursts -> reject_cnt saturates at 255. reset mid-EMIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/touch_sample_filter_pkg.sv
// Shared definitions for the touchscreen sample filter: ADC width, FSM states
// and the per-axis spread test.
package touch_sample_filter_pkg;

    localparam int unsigned ADC_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_EMIT   = 3'd4
    } state_t;

    // max >= min by construction, so a plain unsigned difference is the spread
    function automatic logic spread_ok(input logic [ADC_W-1:0] mx,
                                       input logic [ADC_W-1:0] mn,
                                       input int unsigned      limit);
        logic [ADC_W-1:0] diff;
        diff = mx - mn;
        return (32'(diff) <= limit);
    endfunction

endpackage

// File: rtl/touch_sample_filter_axis_accumulator.sv
// One axis of the burst filter: running sum plus min/max of the current burst.
module touch_sample_filter_axis_accumulator
    import touch_sample_filter_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load_first,
    input  logic                 add,
    input  logic [ADC_W-1:0]     sample,
    output logic [ACC_WIDTH-1:0] sum,
    output logic [ADC_W-1:0]     min,
    output logic [ADC_W-1:0]     max
);

    logic [ACC_WIDTH-1:0] sum_q;
    logic [ADC_W-1:0]     min_q;
    logic [ADC_W-1:0]     max_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else if (add) begin
            if (load_first) begin
                sum_q <= ACC_WIDTH'(sample);
                min_q <= sample;
                max_q <= sample;
            end else begin
                sum_q <= sum_q + ACC_WIDTH'(sample);
                if (sample < min_q) min_q <= sample;
                if (sample > max_q) max_q <= sample;
            end
        end
    end

    assign sum = sum_q;
    assign min = min_q;
    assign max = max_q;

endmodule

// File: rtl/touch_sample_filter.sv
// Averages pen-down ADC bursts, drops settling samples and noisy bursts, and
// hands one coordinate per burst to the painter when it is ready.
module touch_sample_filter
    import touch_sample_filter_pkg::*;
#(
    parameter int unsigned SAMPLE_LOG2     = 2,
    parameter int unsigned DISCARD_SAMPLES = 2,
    parameter int unsigned MAX_SPREAD      = 64,
    parameter int unsigned ACC_WIDTH       = 12 + SAMPLE_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pen_down,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample_x,
    input  logic [ADC_W-1:0] sample_y,
    input  logic             painter_ready,
    output logic             pos_ready,
    output logic [ADC_W-1:0] x_pos,
    output logic [ADC_W-1:0] y_pos,
    output logic             pen_active,
    output logic [7:0]       reject_cnt
);

    localparam int unsigned BURST      = 1 << SAMPLE_LOG2;
    localparam int unsigned BURST_LAST = BURST - 1;
    localparam int unsigned SAMP_W     = (SAMPLE_LOG2 > 0) ? SAMPLE_LOG2 : 1;
    localparam int unsigned DISC_W     = (DISCARD_SAMPLES > 1) ? $clog2(DISCARD_SAMPLES) : 1;
    localparam int unsigned DISC_LAST  = (DISCARD_SAMPLES > 0) ? DISCARD_SAMPLES - 1 : 0;

    state_t              state_q, state_d;
    logic [DISC_W-1:0]   disc_q, disc_d;
    logic [SAMP_W-1:0]   samp_q, samp_d;
    logic [ADC_W-1:0]    x_q, x_d;
    logic [ADC_W-1:0]    y_q, y_d;
    logic [7:0]          rej_q, rej_d;

    logic                acc_clear;
    logic                acc_add;
    logic                acc_load_first;
    logic [ACC_WIDTH-1:0] sum_x, sum_y;
    logic [ADC_W-1:0]    min_x, max_x, min_y, max_y;

    touch_sample_filter_axis_accumulator #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_acc_x (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .load_first (acc_load_first),
        .add        (acc_add),
        .sample     (sample_x),
        .sum        (sum_x),
        .min        (min_x),
        .max        (max_x)
    );

    touch_sample_filter_axis_accumulator #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_acc_y (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .load_first (acc_load_first),
        .add        (acc_add),
        .sample     (sample_y),
        .sum        (sum_y),
        .min        (min_y),
        .max        (max_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            disc_q  <= '0;
            samp_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
            samp_q  <= samp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        disc_d         = disc_q;
        samp_d         = samp_q;
        x_d            = x_q;
        y_d            = y_q;
        rej_d          = rej_q;
        acc_clear      = 1'b0;
        acc_add        = 1'b0;
        acc_load_first = 1'b0;

        if (en) begin
            // pen-up abandons whatever is in flight, including a pending emit
            if (state_q != ST_IDLE && !pen_down) begin
                state_d   = ST_IDLE;
                disc_d    = '0;
                samp_d    = '0;
                acc_clear = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        disc_d    = '0;
                        samp_d    = '0;
                        acc_clear = 1'b1;
                        if (pen_down)
                            state_d = (DISCARD_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (sample_valid) begin
                            if (32'(disc_q) == DISC_LAST) begin
                                disc_d  = '0;
                                state_d = ST_ACCUM;
                            end else begin
                                disc_d = disc_q + DISC_W'(1);
                            end
                        end
                    end
                    ST_ACCUM: begin
                        if (sample_valid) begin
                            acc_add        = 1'b1;
                            acc_load_first = (samp_q == '0);
                            if (32'(samp_q) == BURST_LAST) begin
                                samp_d  = '0;
                                state_d = ST_CHECK;
                            end else begin
                                samp_d = samp_q + SAMP_W'(1);
                            end
                        end
                    end
                    ST_CHECK: begin
                        acc_clear = 1'b1;
                        samp_d    = '0;
                        if (spread_ok(max_x, min_x, MAX_SPREAD) &&
                            spread_ok(max_y, min_y, MAX_SPREAD)) begin
                            x_d     = ADC_W'(sum_x >> SAMPLE_LOG2);
                            y_d     = ADC_W'(sum_y >> SAMPLE_LOG2);
                            state_d = ST_EMIT;
                        end else begin
                            if (rej_q != '1) rej_d = rej_q + 8'd1;
                            state_d = ST_ACCUM;
                        end
                    end
                    ST_EMIT: begin
                        if (painter_ready) state_d = ST_ACCUM;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign pos_ready  = (state_q == ST_EMIT) && painter_ready && pen_down && en;
    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign pen_active = (state_q != ST_IDLE);
    assign reject_cnt = rej_q;

endmodule
